// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Load-use hazard and pipeline-freeze controller for the 5-stage RISC-V core.
// It sits beside the ID stage and steers the front of the pipeline:
//   - a load in ID/EX whose rd feeds an operand that the instruction in ID
//     actually reads (never x0) inserts LOAD_STALL_CYCLES bubbles;
//   - a busy data memory freezes the whole pipeline and holds the hazard
//     sequencer where it is;
//   - a taken branch/jump in ID flushes IF/ID, unless that branch is itself
//     waiting on a load;
//   - a saturating counter tallies every cycle in which the PC does not
//     advance.
//
// Parameters
//   REG_ADDR_W        register index width
//   LOAD_STALL_CYCLES bubbles per load-use hazard, legal range 1..7
//   CNT_W             width of the stall performance counter
//
// Ports
//   clk_i            core clock, rising edge
//   rst_i            synchronous, active-low reset
//   rs1_i / rs2_i    source register indices of the instruction in ID
//   rs1_used_i       instruction in ID reads rs1
//   rs2_used_i       instruction in ID reads rs2
//   id_ex_rd_i       destination index of the instruction in ID/EX
//   id_ex_memread_i  instruction in ID/EX is a load
//   mem_stall_i      data memory busy, freeze the pipeline
//   branch_taken_i   branch/jump resolved taken in ID
//   pc_write_o       PC write enable
//   if_id_write_o    IF/ID write enable
//   no_op_o          select a bubble into ID/EX
//   if_id_flush_o    clear IF/ID on the next edge
//   freeze_o         hold ID/EX, EX/MEM and MEM/WB
//   stall_cnt_o      saturating count of cycles with pc_write_o = 0
//
// All control outputs are combinational from the current state and inputs so
// the pipeline registers act on them at the very next edge; only the counter
// is registered.
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  id_ex_memread_i,
  input  logic                  mem_stall_i,
  input  logic                  branch_taken_i,
  output logic                  pc_write_o,
  output logic                  if_id_write_o,
  output logic                  no_op_o,
  output logic                  if_id_flush_o,
  output logic                  freeze_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_e;

  // Bubbles still owed after the one issued on the cycle the hazard is seen.
  localparam logic [2:0] REM_INIT = 3'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs1_match;
  logic rs2_match;
  logic hz;
  logic stall_active;

  // -------------------------------------------------------------------------
  // Hazard detection
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a value on
  // every path (here by straight assignment, below by defaults at the top),
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    rs1_match = rs1_used_i & (rs1_i == id_ex_rd_i);
    rs2_match = rs2_used_i & (rs2_i == id_ex_rd_i);
    // x0 is hard-wired to zero, so a load targeting it can never be a source.
    hz        = id_ex_memread_i & (id_ex_rd_i != '0) & (rs1_match | rs2_match);
    // In LU_STALL the load has already moved past EX and hz is meaningless;
    // in RUN a live hazard starts the first bubble immediately.
    stall_active = (state_q == LU_STALL) | hz;
  end

  // -------------------------------------------------------------------------
  // Control outputs, highest priority first: reset, memory freeze,
  // load-use stall, normal flow.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    no_op_o       = 1'b0;
    if_id_flush_o = 1'b0;
    freeze_o      = 1'b0;

    if (!rst_i) begin
      // Defaults above are the forced reset values.
    end else if (mem_stall_i) begin
      // Whole pipeline holds; no bubble so the instruction in ID/EX survives.
      freeze_o      = 1'b1;
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if (stall_active) begin
      // A branch in ID that depends on the load is not resolved yet, so its
      // flush request is ignored until the stall ends.
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      no_op_o       = 1'b1;
    end else begin
      if_id_flush_o = branch_taken_i;
    end
  end

  // -------------------------------------------------------------------------
  // Load-use sequencer next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;

    // A frozen pipeline holds the sequencer exactly where it is, so freeze
    // cycles never eat into the bubble budget.
    if (!mem_stall_i) begin
      unique case (state_q)
        RUN: begin
          // With a single bubble the sequencer stays in RUN: the bubble now
          // in ID/EX removes the hazard by itself on the next cycle.
          if (hz && (LOAD_STALL_CYCLES > 1)) begin
            state_d = LU_STALL;
            rem_d   = REM_INIT;
          end
        end
        LU_STALL: begin
          if (rem_q == 3'd1) begin
            state_d = RUN;
            rem_d   = '0;
          end else begin
            rem_d = rem_q - 3'd1;
          end
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Stall performance counter (saturating)
  // -------------------------------------------------------------------------
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: flops are written with non-blocking assignments so every register
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // Any bubbles still owed by an interrupted LU_STALL are abandoned.
      state_q     <= RUN;
      rem_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_control_unit
//
// Four hazard_control_unit instances share one stimulus stream:
//   dut0: LOAD_STALL_CYCLES=1, CNT_W=32
//   dut1: LOAD_STALL_CYCLES=3, CNT_W=32
//   dut2: LOAD_STALL_CYCLES=3, CNT_W=3
//   dut3: LOAD_STALL_CYCLES=7, CNT_W=4
// The reference model keeps, per instance, the number of bubbles still owed
// and the counter value, and derives the expected controls from the rules
// directly. Inputs change on the falling edge, outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_hazard_control_unit;

  localparam int ND = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       memread;
    logic       mem_stall;
    logic       branch;
  } stim_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs1_i, rs2_i, id_ex_rd_i;
  logic       rs1_used_i, rs2_used_i, id_ex_memread_i, mem_stall_i, branch_taken_i;

  logic pw  [ND];
  logic ifw [ND];
  logic nop [ND];
  logic fl  [ND];
  logic fz  [ND];
  logic [31:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  logic [3:0]  cnt3;

  // {pc_write, if_id_write, no_op, if_id_flush, freeze}
  logic [4:0]  act_v   [ND];
  logic [31:0] act_cnt [ND];

  int total = 0;
  int bad   = 0;

  // Reference model state
  int      ncyc [ND];
  longint  cmax [ND];
  int      nb   [ND];
  longint  mcnt [ND];

  always #5 clk_i = ~clk_i;

  always_comb begin
    for (int k = 0; k < ND; k++) act_v[k] = {pw[k], ifw[k], nop[k], fl[k], fz[k]};
    act_cnt[0] = cnt0;
    act_cnt[1] = cnt1;
    act_cnt[2] = {29'd0, cnt2};
    act_cnt[3] = {28'd0, cnt3};
  end

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(32)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .id_ex_rd_i(id_ex_rd_i),
    .id_ex_memread_i(id_ex_memread_i), .mem_stall_i(mem_stall_i),
    .branch_taken_i(branch_taken_i), .pc_write_o(pw[0]), .if_id_write_o(ifw[0]),
    .no_op_o(nop[0]), .if_id_flush_o(fl[0]), .freeze_o(fz[0]), .stall_cnt_o(cnt0));

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(32)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .id_ex_rd_i(id_ex_rd_i),
    .id_ex_memread_i(id_ex_memread_i), .mem_stall_i(mem_stall_i),
    .branch_taken_i(branch_taken_i), .pc_write_o(pw[1]), .if_id_write_o(ifw[1]),
    .no_op_o(nop[1]), .if_id_flush_o(fl[1]), .freeze_o(fz[1]), .stall_cnt_o(cnt1));

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(3)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .id_ex_rd_i(id_ex_rd_i),
    .id_ex_memread_i(id_ex_memread_i), .mem_stall_i(mem_stall_i),
    .branch_taken_i(branch_taken_i), .pc_write_o(pw[2]), .if_id_write_o(ifw[2]),
    .no_op_o(nop[2]), .if_id_flush_o(fl[2]), .freeze_o(fz[2]), .stall_cnt_o(cnt2));

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(7), .CNT_W(4)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .id_ex_rd_i(id_ex_rd_i),
    .id_ex_memread_i(id_ex_memread_i), .mem_stall_i(mem_stall_i),
    .branch_taken_i(branch_taken_i), .pc_write_o(pw[3]), .if_id_write_o(ifw[3]),
    .no_op_o(nop[3]), .if_id_flush_o(fl[3]), .freeze_o(fz[3]), .stall_cnt_o(cnt3));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit hz_ref();
    return id_ex_memread_i && (id_ex_rd_i != 5'd0) &&
           ((rs1_used_i && (rs1_i == id_ex_rd_i)) || (rs2_used_i && (rs2_i == id_ex_rd_i)));
  endfunction

  function automatic logic [4:0] exp_v(int k);
    if (!rst_i)               return 5'b11000;
    if (mem_stall_i)          return 5'b00001;
    if (nb[k] > 0 || hz_ref()) return 5'b00100;
    return {3'b110, branch_taken_i, 1'b0};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic stim_t hazard_rs1();
    stim_t s;
    s          = idle();
    s.memread  = 1'b1;
    s.rd       = 5'd5;
    s.rs1      = 5'd5;
    s.rs1_used = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst_i           = s.rst;
    rs1_i           = s.rs1;
    rs2_i           = s.rs2;
    rs1_used_i      = s.rs1_used;
    rs2_used_i      = s.rs2_used;
    id_ex_rd_i      = s.rd;
    id_ex_memread_i = s.memread;
    mem_stall_i     = s.mem_stall;
    branch_taken_i  = s.branch;
    #1;
  endtask

  // Advance one clock: model absorbs the edge with the inputs currently held.
  task automatic tick();
    logic [4:0] e;
    @(posedge clk_i);
    for (int k = 0; k < ND; k++) begin
      e = exp_v(k);
      if (!rst_i) begin
        nb[k]   = 0;
        mcnt[k] = 0;
      end else begin
        if (!e[4] && mcnt[k] < cmax[k]) mcnt[k]++;
        if (!mem_stall_i) begin
          if (nb[k] > 0)      nb[k]--;
          else if (hz_ref()) nb[k] = ncyc[k] - 1;
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic reset_all();
    stim_t s;
    s     = idle();
    s.rst = 1'b0;
    drive(s);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    stim_t s;
    s           = hazard_rs1();
    s.rst       = 1'b0;
    s.mem_stall = 1'b1;
    s.branch    = 1'b1;
    drive(s);
    for (int k = 0; k < ND; k++) begin
      total++;
      if (act_v[k] !== 5'b11000) begin
        bad++;
        $display("FAIL reset_ctrl dut%0d got=%b want=11000", k, act_v[k]);
      end
    end
    tick();
    drive(s);
    for (int k = 0; k < ND; k++) begin
      total++;
      if (act_v[k] !== 5'b11000) begin
        bad++;
        $display("FAIL reset_ctrl2 dut%0d got=%b want=11000", k, act_v[k]);
      end
      total++;
      if (act_cnt[k] !== 32'd0) begin
        bad++;
        $display("FAIL reset_cnt dut%0d got=%0d want=0", k, act_cnt[k]);
      end
    end
    tick();
  endtask

  task automatic test_load_use();
    stim_t s;
    int    nops   [ND] = '{0, 0, 0, 0};
    int    want_b [ND] = '{1, 3, 3, 7};
    reset_all();
    for (int c = 0; c < 10; c++) begin
      s = hazard_rs1();
      if (c > 0) s.memread = 1'b0;  // bubble now sits in ID/EX
      drive(s);
      for (int k = 0; k < ND; k++) begin
        total++;
        if (act_v[k] !== exp_v(k)) begin
          bad++;
          $display("FAIL load_use_ctrl dut%0d cyc%0d got=%b want=%b", k, c, act_v[k], exp_v(k));
        end
        total++;
        if (act_cnt[k] !== 32'(mcnt[k])) begin
          bad++;
          $display("FAIL load_use_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, act_cnt[k], mcnt[k]);
        end
        nops[k] += int'(nop[k]);
      end
      tick();
    end
    for (int k = 0; k < ND; k++) begin
      total++;
      if (nops[k] != want_b[k]) begin
        bad++;
        $display("FAIL load_use_bubbles dut%0d got=%0d want=%0d", k, nops[k], want_b[k]);
      end
      total++;
      if (act_cnt[k] !== 32'(want_b[k])) begin
        bad++;
        $display("FAIL load_use_total dut%0d got=%0d want=%0d", k, act_cnt[k], want_b[k]);
      end
    end
  endtask

  task automatic test_no_stall();
    stim_t s [2];
    reset_all();
    s[0] = idle();
    s[0].memread = 1'b1; s[0].rd = 5'd0; s[0].rs1 = 5'd0; s[0].rs1_used = 1'b1;
    s[0].rs2 = 5'd0; s[0].rs2_used = 1'b1;
    s[1] = idle();
    s[1].memread = 1'b1; s[1].rd = 5'd7; s[1].rs2 = 5'd7; s[1].rs2_used = 1'b0;
    s[1].rs1 = 5'd3; s[1].rs1_used = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(s[c]);
      for (int k = 0; k < ND; k++) begin
        total++;
        if (act_v[k] !== 5'b11000) begin
          bad++;
          $display("FAIL no_stall_ctrl dut%0d case%0d got=%b want=11000", k, c, act_v[k]);
        end
      end
      tick();
    end
    for (int k = 0; k < ND; k++) begin
      total++;
      if (act_cnt[k] !== 32'd0) begin
        bad++;
        $display("FAIL no_stall_cnt dut%0d got=%0d want=0", k, act_cnt[k]);
      end
    end
  endtask

  task automatic test_freeze();
    stim_t s;
    int    nops1 = 0;
    int    frz1  = 0;
    reset_all();
    for (int c = 0; c < 8; c++) begin
      s = hazard_rs1();
      if (c > 0) s.memread = 1'b0;
      s.mem_stall = (c == 2 || c == 3);
      drive(s);
      for (int k = 0; k < ND; k++) begin
        total++;
        if (act_v[k] !== exp_v(k)) begin
          bad++;
          $display("FAIL freeze_ctrl dut%0d cyc%0d got=%b want=%b", k, c, act_v[k], exp_v(k));
        end
        total++;
        if (act_cnt[k] !== 32'(mcnt[k])) begin
          bad++;
          $display("FAIL freeze_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, act_cnt[k], mcnt[k]);
        end
      end
      nops1 += int'(nop[1]);
      frz1  += int'(fz[1]);
      tick();
    end
    total++;
    if (nops1 != 3 || frz1 != 2) begin
      bad++;
      $display("FAIL freeze_mix dut1 bubbles=%0d freezes=%0d want 3 and 2", nops1, frz1);
    end
    total++;
    if (cnt1 !== 32'd5) begin
      bad++;
      $display("FAIL freeze_total dut1 got=%0d want=5", cnt1);
    end
  endtask

  task automatic test_branch_flush();
    stim_t      s;
    logic [4:0] fl_seq = '0;
    reset_all();
    for (int c = 0; c < 5; c++) begin
      s = hazard_rs1();
      if (c > 0) s.memread = 1'b0;
      s.branch = (c < 4);
      drive(s);
      for (int k = 0; k < ND; k++) begin
        total++;
        if (act_v[k] !== exp_v(k)) begin
          bad++;
          $display("FAIL branch_ctrl dut%0d cyc%0d got=%b want=%b", k, c, act_v[k], exp_v(k));
        end
      end
      fl_seq[c] = fl[1];
      tick();
    end
    total++;
    if (fl_seq !== 5'b01000) begin
      bad++;
      $display("FAIL branch_flush_seq dut1 got=%b want=01000", fl_seq);
    end
  endtask

  task automatic test_saturation();
    stim_t s;
    reset_all();
    s           = idle();
    s.mem_stall = 1'b1;
    for (int c = 0; c < 9; c++) begin
      drive(s);
      for (int k = 0; k < ND; k++) begin
        total++;
        if (act_cnt[k] !== 32'(mcnt[k])) begin
          bad++;
          $display("FAIL sat_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, act_cnt[k], mcnt[k]);
        end
      end
      tick();
    end
    total++;
    if (cnt2 !== 3'd7 || cnt3 !== 4'd9) begin
      bad++;
      $display("FAIL sat_final dut2=%0d dut3=%0d want 7 and 9", cnt2, cnt3);
    end
    // Enter LU_STALL, then reset for a single edge.
    drive(hazard_rs1());
    tick();
    s     = idle();
    s.rst = 1'b0;
    drive(s);
    total++;
    if (act_v[2] !== 5'b11000) begin
      bad++;
      $display("FAIL sat_rst_ctrl dut2 got=%b want=11000", act_v[2]);
    end
    tick();
    drive(idle());
    for (int k = 0; k < ND; k++) begin
      total++;
      if (act_v[k] !== 5'b11000) begin
        bad++;
        $display("FAIL post_rst_ctrl dut%0d got=%b want=11000", k, act_v[k]);
      end
      total++;
      if (act_cnt[k] !== 32'd0) begin
        bad++;
        $display("FAIL post_rst_cnt dut%0d got=%0d want=0", k, act_cnt[k]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    stim_t s;
    reset_all();
    for (int c = 0; c < 600; c++) begin
      s.rst       = ($urandom_range(0, 39) != 0);
      s.rs1       = 5'($urandom_range(0, 3));
      s.rs2       = 5'($urandom_range(0, 3));
      s.rs1_used  = 1'($urandom_range(0, 1));
      s.rs2_used  = 1'($urandom_range(0, 1));
      s.rd        = 5'($urandom_range(0, 3));
      s.memread   = 1'($urandom_range(0, 1));
      s.mem_stall = ($urandom_range(0, 7) == 0);
      s.branch    = 1'($urandom_range(0, 1));
      drive(s);
      for (int k = 0; k < ND; k++) begin
        total++;
        if (act_v[k] !== exp_v(k)) begin
          bad++;
          $display("FAIL random_ctrl dut%0d cyc%0d got=%b want=%b", k, c, act_v[k], exp_v(k));
        end
        total++;
        if (act_cnt[k] !== 32'(mcnt[k])) begin
          bad++;
          $display("FAIL random_cnt dut%0d cyc%0d got=%0d want=%0d", k, c, act_cnt[k], mcnt[k]);
        end
      end
      tick();
    end
  endtask

  initial begin
    ncyc = '{1, 3, 3, 7};
    cmax = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7, 64'd15};
    for (int k = 0; k < ND; k++) begin
      nb[k]   = 0;
      mcnt[k] = 0;
    end
    test_reset();
    test_load_use();
    test_no_stall();
    test_freeze();
    test_branch_flush();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
